// File: rtl/img_pkg.sv
// Shared constants and types for the pixel-processing pipeline stages.
// Coefficients are the BT.601 full-range inverse matrix scaled by 256.
package img_pkg;

    localparam int PIPE_LAT   = 3;
    localparam int CHROMA_OFS = 128;
    localparam int SYNC_W     = 3;

    localparam logic signed [17:0] K_RCR = 18'sd359;
    localparam logic signed [17:0] K_GCB = 18'sd88;
    localparam logic signed [17:0] K_GCR = 18'sd183;
    localparam logic signed [17:0] K_BCB = 18'sd454;

    typedef struct packed {
        logic clken;
        logic href;
        logic vsync;
    } sync_t;

endpackage

// File: rtl/ycbcr_rgb565_sync_delay.sv
// Generic N-deep, W-wide shift register that clears to 0 on reset.
// Keeps frame syncs aligned with a fixed-latency data pipeline.
module sync_delay #(
    parameter int N = 3,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_reg [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[0] <= '0;
                    else        stage_reg[0] <= din;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[N-1];

endmodule

// File: rtl/ycbcr_rgb565.sv
// YCbCr 4:4:4 (BT.601 full range) to RGB888/RGB565 converter.
// Free-running 3-stage pipeline: products, sums, shift+clamp.
module ycbcr_rgb565
    import img_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_clken,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic [7:0]  img_Y,
    input  logic [7:0]  img_Cb,
    input  logic [7:0]  img_Cr,
    output logic        post_frame_clken,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic [23:0] rgb888,
    output logic [15:0] rgb565
);

    localparam logic signed [17:0] RND = ROUND_EN ? 18'sd128 : 18'sd0;

    // Sums are 18-bit signed; >>>8 leaves a 10-bit signed value to saturate.
    function automatic logic [7:0] clamp8(input logic signed [17:0] s);
        logic signed [9:0] v;
        v = s[17:8];
        if (v < 10'sd0)        return 8'h00;
        else if (v > 10'sd255) return 8'hFF;
        else                   return v[7:0];
    endfunction

    logic signed [8:0]  dcb;
    logic signed [8:0]  dcr;
    logic signed [17:0] dcb_ext;
    logic signed [17:0] dcr_ext;

    assign dcb     = {1'b0, img_Cb} - 9'(CHROMA_OFS);
    assign dcr     = {1'b0, img_Cr} - 9'(CHROMA_OFS);
    assign dcb_ext = {{9{dcb[8]}}, dcb};
    assign dcr_ext = {{9{dcr[8]}}, dcr};

    logic signed [17:0] y256_reg;
    logic signed [17:0] p_rcr_reg;
    logic signed [17:0] p_gcb_reg;
    logic signed [17:0] p_gcr_reg;
    logic signed [17:0] p_bcb_reg;

    logic signed [17:0] sum_r_reg;
    logic signed [17:0] sum_g_reg;
    logic signed [17:0] sum_b_reg;

    logic [7:0] r_reg;
    logic [7:0] g_reg;
    logic [7:0] b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y256_reg  <= '0;
            p_rcr_reg <= '0;
            p_gcb_reg <= '0;
            p_gcr_reg <= '0;
            p_bcb_reg <= '0;
        end else begin
            y256_reg  <= {2'b00, img_Y, 8'h00};
            p_rcr_reg <= dcr_ext * K_RCR;
            p_gcb_reg <= dcb_ext * K_GCB;
            p_gcr_reg <= dcr_ext * K_GCR;
            p_bcb_reg <= dcb_ext * K_BCB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_reg <= '0;
            sum_g_reg <= '0;
            sum_b_reg <= '0;
        end else begin
            sum_r_reg <= y256_reg + p_rcr_reg + RND;
            sum_g_reg <= y256_reg - p_gcb_reg - p_gcr_reg + RND;
            sum_b_reg <= y256_reg + p_bcb_reg + RND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
            g_reg <= '0;
            b_reg <= '0;
        end else begin
            r_reg <= clamp8(sum_r_reg);
            g_reg <= clamp8(sum_g_reg);
            b_reg <= clamp8(sum_b_reg);
        end
    end

    sync_t sync_in;
    sync_t sync_out;

    assign sync_in.clken = per_frame_clken;
    assign sync_in.href  = per_frame_href;
    assign sync_in.vsync = per_frame_vsync;

    sync_delay #(
        .N (PIPE_LAT),
        .W (SYNC_W)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sync_in),
        .dout  (sync_out)
    );

    assign post_frame_clken = sync_out.clken;
    assign post_frame_href  = sync_out.href;
    assign post_frame_vsync = sync_out.vsync;

    // Blank pixel data outside active lines.
    assign rgb888 = post_frame_href ? {r_reg, g_reg, b_reg} : 24'h000000;
    assign rgb565 = post_frame_href ? {r_reg[7:3], g_reg[7:2], b_reg[7:3]} : 16'h0000;

endmodule

// File: tb/tb_ycbcr_rgb565.sv
// Directed bench for ycbcr_rgb565 with hand-computed expected pixels.
module tb_ycbcr_rgb565;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clken;
    logic        vsync;
    logic        href;
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic        post_clken;
    logic        post_vsync;
    logic        post_href;
    logic [23:0] rgb888;
    logic [15:0] rgb565;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ycbcr_rgb565 #(.ROUND_EN(1'b1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_clken  (clken),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .img_Y            (y),
        .img_Cb           (cb),
        .img_Cr           (cr),
        .post_frame_clken (post_clken),
        .post_frame_vsync (post_vsync),
        .post_frame_href  (post_href),
        .rgb888           (rgb888),
        .rgb565           (rgb565)
    );

    task automatic drive(input logic [7:0] yy, input logic [7:0] cbv,
                         input logic [7:0] crv, input logic h, input logic vs);
        y     = yy;
        cb    = cbv;
        cr    = crv;
        href  = h;
        clken = h;
        vsync = vs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'($urandom));
            tick();
            total_cnt++;
            if ({post_clken, post_vsync, post_href, rgb888, rgb565} !== 43'd0)
                $display("FAIL reset_hold[%0d]: got sync=%b%b%b rgb888=%h rgb565=%h, need all 0",
                         i, post_clken, post_vsync, post_href, rgb888, rgb565);
            else pass_cnt++;
        end
        drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total_cnt++;
            if (k < 3) begin
                if ({post_href, rgb888} !== 25'd0)
                    $display("FAIL reset_refill[%0d]: href=%b rgb888=%h, need 0", k, post_href, rgb888);
                else pass_cnt++;
            end else begin
                if (post_href !== 1'b1 || rgb888 !== 24'h808080 || rgb565 !== 16'h8410)
                    $display("FAIL reset_release: href=%b rgb888=%h rgb565=%h, need 1 808080 8410",
                             post_href, rgb888, rgb565);
                else pass_cnt++;
            end
        end
        $display("reset: done");
    endtask

    task automatic test_latency();
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
        repeat (4) tick();
        drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
            total_cnt++;
            if (k == 3) begin
                if (post_href !== 1'b1 || rgb888 !== 24'h808080 || rgb565 !== 16'h8410)
                    $display("FAIL latency_hit: href=%b rgb888=%h rgb565=%h, need 1 808080 8410",
                             post_href, rgb888, rgb565);
                else pass_cnt++;
            end else begin
                if ({post_href, rgb888, rgb565} !== 41'd0)
                    $display("FAIL latency_edge[%0d]: href=%b rgb888=%h rgb565=%h, need 0",
                             k, post_href, rgb888, rgb565);
                else pass_cnt++;
            end
        end
        $display("latency: mid-gray pixel checked at 3 clk");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ty  [6] = '{8'd255, 8'd0,   8'd255, 8'd0,   8'd100, 8'd200};
        logic [7:0]  tcb [6] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd150, 8'd60};
        logic [7:0]  tcr [6] = '{8'd128, 8'd128, 8'd255, 8'd0,   8'd110, 8'd220};
        logic [23:0] e888[6] = '{24'hFFFFFF, 24'h000000, 24'hFFA4FF, 24'h005C00, 24'h4B698B, 24'hFF9E4F};
        logic [15:0] e565[6] = '{16'hFFFF, 16'h0000, 16'hFD3F, 16'h02E0, 16'h4B51, 16'hFCE9};
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(ty[i], tcb[i], tcr[i], 1'b1, 1'b0);
            else       drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
            tick();
            if (i >= 2) begin
                total_cnt++;
                if (post_href !== 1'b1 || rgb888 !== e888[i-2] || rgb565 !== e565[i-2])
                    $display("FAIL b2b_pixel[%0d]: href=%b rgb888=%h rgb565=%h, need 1 %h %h",
                             i - 2, post_href, rgb888, rgb565, e888[i-2], e565[i-2]);
                else pass_cnt++;
                $display("b2b: pixel %0d rgb888=%h rgb565=%h", i - 2, rgb888, rgb565);
            end
        end
    endtask

    task automatic test_sync_alignment();
        logic       vs_hist [15];
        logic [7:0] ey;
        logic       eh;
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
        repeat (4) tick();
        for (int i = 0; i < 15; i++) begin
            vs_hist[i] = (i >= 4 && i < 6);
            drive(8'(i + 10), 8'd128, 8'd128, i < 10, vs_hist[i]);
            tick();
            if (i >= 2) begin
                eh = (i - 2) < 10;
                ey = 8'(i + 8);
                total_cnt++;
                if (post_href !== eh || post_clken !== eh || post_vsync !== vs_hist[i-2])
                    $display("FAIL sync_align[%0d]: clken=%b href=%b vsync=%b, need %b %b %b",
                             i - 2, post_clken, post_href, post_vsync, eh, eh, vs_hist[i-2]);
                else pass_cnt++;
                total_cnt++;
                if (eh) begin
                    if (rgb888 !== {ey, ey, ey} || rgb565 !== {ey[7:3], ey[7:2], ey[7:3]})
                        $display("FAIL ramp_pixel[%0d]: rgb888=%h rgb565=%h, need %h %h",
                                 i - 2, rgb888, rgb565, {ey, ey, ey}, {ey[7:3], ey[7:2], ey[7:3]});
                    else pass_cnt++;
                end else begin
                    if ({rgb888, rgb565} !== 40'd0)
                        $display("FAIL ramp_gate[%0d]: rgb888=%h rgb565=%h, need 0", i - 2, rgb888, rgb565);
                    else pass_cnt++;
                end
            end
        end
        $display("sync: 10-pixel ramp with mid-line vsync checked");
    endtask

    task automatic test_reset_midline();
        drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b1);
        repeat (5) tick();
        total_cnt++;
        if (post_href !== 1'b1 || rgb888 !== 24'h808080)
            $display("FAIL midline_pre: href=%b rgb888=%h, need 1 808080", post_href, rgb888);
        else pass_cnt++;
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({post_clken, post_vsync, post_href, rgb888, rgb565} !== 43'd0)
            $display("FAIL midline_async: sync=%b%b%b rgb888=%h, need all 0",
                     post_clken, post_vsync, post_href, rgb888);
        else pass_cnt++;
        repeat (2) tick();
        total_cnt++;
        if ({post_clken, post_vsync, post_href, rgb888, rgb565} !== 43'd0)
            $display("FAIL midline_hold: sync=%b%b%b rgb888=%h, need all 0",
                     post_clken, post_vsync, post_href, rgb888);
        else pass_cnt++;
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        drive(8'd100, 8'd150, 8'd110, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
            total_cnt++;
            if (k < 3) begin
                if ({post_href, rgb888} !== 25'd0)
                    $display("FAIL midline_refill[%0d]: href=%b rgb888=%h, need 0", k, post_href, rgb888);
                else pass_cnt++;
            end else begin
                if (post_href !== 1'b1 || rgb888 !== 24'h4B698B || rgb565 !== 16'h4B51)
                    $display("FAIL midline_first: href=%b rgb888=%h rgb565=%h, need 1 4b698b 4b51",
                             post_href, rgb888, rgb565);
                else pass_cnt++;
            end
        end
        $display("midline reset: recovery pixel checked");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        test_reset();
        test_latency();
        test_back_to_back();
        test_sync_alignment();
        test_reset_midline();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
